uart_prot_trig: RTL and testbench
=================================

UART_PROT_TRIG -- requirements
Module: uart_prot_trig

Interface
REQ-001 SHALL have parameter BAUD_W, default 16, the width of the baud-period input and of the bit-timing counter.
REQ-002 SHALL have port clk, input, 1 bit: the system clock (100 MHz); all flops are clocked on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous to clk and active-low.
REQ-004 SHALL have port RX, input, 1 bit: raw channel line, asynchronous to clk, idle high.
REQ-005 SHALL have port baud_cnt, input, BAUD_W bits: bit period in clk cycles.
REQ-006 SHALL have port match, input, 8 bits: byte value to trigger on.
REQ-007 SHALL have port mask, input, 8 bits: per-bit don't-care; 1 = ignore that bit in the compare.
REQ-008 SHALL have port armed, input, 1 bit: trigger enable.
REQ-009 SHALL have port UART_trig, output, 1 bit: single-cycle pulse on a matching frame.
REQ-010 SHALL have port frm_err, output, 1 bit: single-cycle pulse on a stop-bit error.
REQ-011 SHALL have port rx_data, output, 8 bits: last fully received byte.
REQ-012 SHALL have port busy, output, 1 bit: high while the FSM is in any state other than IDLE.

Function
REQ-013 SHALL pass RX through two synchronizer flops and then one edge-detect flop; a falling edge SHALL be seen 3 clk cycles after RX falls.
REQ-014 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-015 IDLE -> START on a synchronized falling edge; at this transition SHALL latch the bit period, clamped to a minimum of 2 if baud_cnt < 2, and load the counter with period>>1.
REQ-016 SHALL use the latched period for the whole frame; changes to baud_cnt mid-frame SHALL have no effect until the next frame.
REQ-017 START: when the counter expires, SHALL sample RX; if RX = 1, treat it as a false start, go to IDLE and raise no output; if RX = 0, go to DATA and reload the counter with the full period.
REQ-018 DATA: SHALL sample one bit on each counter expiry and shift it in LSB-first (shift right, new bit into bit 7); after the 8th sample SHALL go to STOP, reloading the full period.
REQ-019 STOP: when the counter expires, SHALL sample RX and go to IDLE on the next cycle; RX = 1 makes a valid frame, RX = 0 is a framing error.
REQ-020 On a valid frame, rx_data SHALL update with the shift register one cycle after the stop sample.
REQ-021 On a valid frame with armed = 1 and ((shift ^ match) & ~mask) == 0, UART_trig SHALL pulse high for exactly one cycle, one cycle after the stop sample.
REQ-022 On a framing error, frm_err SHALL pulse one cycle, one cycle after the stop sample; UART_trig SHALL stay 0 and rx_data SHALL be unchanged.
REQ-023 SHALL evaluate armed only at the stop sample; arming or disarming mid-frame SHALL affect only that evaluation.
REQ-024 mask = 8'hFF SHALL cause every valid frame to trigger while armed.
REQ-025 After a framing error with RX held low (break), SHALL require RX to return high and fall again before starting a new frame.
REQ-026 A falling edge arriving during STOP or in the same cycle as the STOP -> IDLE transition SHALL NOT be lost; IDLE SHALL accept an edge detected on the cycle it is entered.
REQ-027 UART_trig and frm_err SHALL never be asserted in the same cycle.

Reset
REQ-028 When rst_n = 0 at a rising clk edge, SHALL force: state IDLE; counter, bit index and shift register to 0; UART_trig = 0; frm_err = 0; busy = 0; rx_data = 8'h00; synchronizer and edge flops to 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the block SHALL wait for a new falling edge.

Verification
REQ-030 SHALL cover: baud_cnt = 16, match = 8'h96, mask = 8'h00, armed = 1, send 8'h96 -> one UART_trig pulse, rx_data = 8'h96, frm_err = 0.
REQ-031 SHALL cover: same setup, send 8'h97 -> no UART_trig; rx_data = 8'h97.
REQ-032 SHALL cover: mask = 8'h01, send 8'h97 -> one UART_trig pulse; repeat with armed = 0 -> no pulse.
REQ-033 SHALL cover: baud_cnt = 16, RX low for 4 cycles only -> false start, busy drops after the half period, no pulses.
REQ-034 SHALL cover: RX held low for 12 bit periods -> one frm_err pulse with rx_data unchanged; no new frame until RX rises and falls again.
REQ-035 SHALL cover: rst_n = 0 during DATA bit 4 -> all outputs 0 and state IDLE; the next full frame 8'h96 is received and triggers correctly.

Source files
------------

// File: rtl/uart_prot_trig.sv
// UART protocol trigger: receives 8N1 frames on RX and pulses UART_trig when a
// valid frame matches the masked compare value while armed.
module uart_prot_trig #(
  parameter int BAUD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  input  logic [BAUD_W-1:0] baud_cnt,
  input  logic [7:0]        match,
  input  logic [7:0]        mask,
  input  logic              armed,
  output logic              UART_trig,
  output logic              frm_err,
  output logic [7:0]        rx_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic              sync1;
  logic              sync2;
  logic              edge_q;
  logic              pend;
  logic [BAUD_W-1:0] period;
  logic [BAUD_W-1:0] cnt;
  logic [BAUD_W-1:0] per_next;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              fall;
  logic              expire;
  logic              hit;

  assign fall     = edge_q & ~sync2;
  assign expire   = (cnt <= BAUD_W'(1));
  assign per_next = (baud_cnt < BAUD_W'(2)) ? BAUD_W'(2) : baud_cnt;
  assign hit      = (((shift ^ match) & ~mask) == 8'h00);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      edge_q <= 1'b1;
    end else begin
      sync1  <= RX;
      sync2  <= sync1;
      edge_q <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      period    <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      pend      <= 1'b0;
      UART_trig <= 1'b0;
      frm_err   <= 1'b0;
      rx_data   <= '0;
    end else begin
      UART_trig <= 1'b0;
      frm_err   <= 1'b0;
      case (state)
        IDLE: begin
          pend <= 1'b0;
          if (fall || pend) begin
            period <= per_next;
            cnt    <= per_next >> 1;
            state  <= START;
          end
        end
        START: begin
          if (expire) begin
            if (sync2) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cnt     <= period;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt - BAUD_W'(1);
          end
        end
        DATA: begin
          if (expire) begin
            shift <= {sync2, shift[7:1]};
            cnt   <= period;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - BAUD_W'(1);
          end
        end
        STOP: begin
          // An edge seen here would otherwise be gone by the time IDLE looks.
          if (fall) begin
            pend <= 1'b1;
          end
          if (expire) begin
            state <= IDLE;
            if (sync2) begin
              rx_data   <= shift;
              UART_trig <= armed & hit;
            end else begin
              frm_err <= 1'b1;
            end
          end else begin
            cnt <= cnt - BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prot_trig.sv
// Directed bench for uart_prot_trig: frames, masking, arming, false start,
// break/framing error and mid-frame reset.
module tb_uart_prot_trig;

  logic        clk;
  logic        rst_n;
  logic        RX;
  logic [15:0] baud_cnt;
  logic [7:0]  match;
  logic [7:0]  mask;
  logic        armed;
  logic        UART_trig;
  logic        frm_err;
  logic [7:0]  rx_data;
  logic        busy;

  int checks;
  int errors;
  int trig_n;
  int err_n;
  int both_n;
  int t0;
  int e0;

  uart_prot_trig #(.BAUD_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .baud_cnt  (baud_cnt),
    .match     (match),
    .mask      (mask),
    .armed     (armed),
    .UART_trig (UART_trig),
    .frm_err   (frm_err),
    .rx_data   (rx_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    trig_n = 0;
    err_n  = 0;
    both_n = 0;
  end

  always @(negedge clk) begin
    if (UART_trig === 1'b1) trig_n++;
    if (frm_err === 1'b1) err_n++;
    if (UART_trig === 1'b1 && frm_err === 1'b1) both_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mid: 0 plain, 1 change baud_cnt after the start bit, 2 set armed during bit 3
  task automatic send_byte(input logic [7:0] b, input int mid);
    RX = 1'b0;
    wait_cyc(16);
    if (mid == 1) baud_cnt = 16'd40;
    for (int i = 0; i < 8; i++) begin
      if (mid == 2 && i == 3) armed = 1'b1;
      RX = b[i];
      wait_cyc(16);
    end
    RX = 1'b1;
    wait_cyc(16);
    baud_cnt = 16'd16;
    wait_cyc(8);
  endtask

  initial begin
    logic [7:0] v;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    RX       = 1'b1;
    baud_cnt = 16'd16;
    match    = 8'h96;
    mask     = 8'h00;
    armed    = 1'b1;
    wait_cyc(3);
    check("rst_trig", {31'd0, UART_trig}, 32'd0);
    check("rst_frm", {31'd0, frm_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'h00);
    rst_n = 1'b1;
    wait_cyc(5);

    t0 = trig_n; e0 = err_n;
    send_byte(8'h96, 0);
    check("m96_trig", trig_n - t0, 1);
    check("m96_data", {24'd0, rx_data}, 32'h96);
    check("m96_frm", err_n - e0, 0);

    t0 = trig_n;
    send_byte(8'h97, 0);
    check("m97_trig", trig_n - t0, 0);
    check("m97_data", {24'd0, rx_data}, 32'h97);

    mask = 8'h01;
    t0 = trig_n;
    send_byte(8'h97, 0);
    check("mask01_trig", trig_n - t0, 1);
    armed = 1'b0;
    t0 = trig_n;
    send_byte(8'h97, 0);
    check("disarm_trig", trig_n - t0, 0);
    check("disarm_data", {24'd0, rx_data}, 32'h97);

    mask = 8'hFF;
    armed = 1'b1;
    t0 = trig_n;
    send_byte(8'h3C, 0);
    check("maskff_trig", trig_n - t0, 1);
    check("maskff_data", {24'd0, rx_data}, 32'h3C);

    mask = 8'h00;
    armed = 1'b0;
    t0 = trig_n;
    send_byte(8'h96, 2);
    check("armmid_trig", trig_n - t0, 1);

    t0 = trig_n;
    send_byte(8'h5A, 1);
    check("baudmid_data", {24'd0, rx_data}, 32'h5A);
    check("baudmid_trig", trig_n - t0, 0);

    t0 = trig_n; e0 = err_n;
    RX = 1'b0;
    wait_cyc(4);
    RX = 1'b1;
    wait_cyc(6);
    check("fs_busy10", {31'd0, busy}, 32'd1);
    wait_cyc(1);
    check("fs_busy11", {31'd0, busy}, 32'd0);
    wait_cyc(20);
    check("fs_trig", trig_n - t0, 0);
    check("fs_frm", err_n - e0, 0);
    check("fs_data", {24'd0, rx_data}, 32'h5A);

    t0 = trig_n; e0 = err_n;
    RX = 1'b0;
    wait_cyc(192);
    check("brk_frm", err_n - e0, 1);
    check("brk_trig", trig_n - t0, 0);
    check("brk_data", {24'd0, rx_data}, 32'h5A);
    check("brk_busy", {31'd0, busy}, 32'd0);
    RX = 1'b1;
    wait_cyc(20);
    check("brk_idle", {31'd0, busy}, 32'd0);
    check("brk_frm_once", err_n - e0, 1);
    t0 = trig_n;
    send_byte(8'h96, 0);
    check("postbrk_trig", trig_n - t0, 1);
    check("postbrk_data", {24'd0, rx_data}, 32'h96);

    v = 8'h96;
    t0 = trig_n; e0 = err_n;
    RX = 1'b0;
    wait_cyc(16);
    for (int i = 0; i < 4; i++) begin
      RX = v[i];
      wait_cyc(16);
    end
    RX = v[4];
    wait_cyc(8);
    check("bit4_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    wait_cyc(2);
    check("mrst_trig", {31'd0, UART_trig}, 32'd0);
    check("mrst_frm", {31'd0, frm_err}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_data", {24'd0, rx_data}, 32'h00);
    RX = 1'b1;
    rst_n = 1'b1;
    wait_cyc(120);
    check("mrst_idle", {31'd0, busy}, 32'd0);
    check("mrst_nopulse", (trig_n - t0) + (err_n - e0), 0);
    t0 = trig_n;
    send_byte(8'h96, 0);
    check("mrst_rx_trig", trig_n - t0, 1);
    check("mrst_rx_data", {24'd0, rx_data}, 32'h96);

    check("never_both", both_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
